// File: rtl/shift_register.sv
// Serial-in, parallel-out shift register.
// New bits enter at bit 0; the oldest bit falls off the MSB.
module shift_register #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x_i,
    output logic [WIDTH-1:0] sr_o
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    always_comb begin
        sr_d = {sr_q[WIDTH-2:0], x_i};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    // Output comes straight from the flops; x_i never reaches sr_o combinationally.
    assign sr_o = sr_q;

endmodule

// File: tb/tb_shift_register.sv
// Bench for shift_register: directed scenarios plus random serial
// traffic against a history-queue model of the last WIDTH inputs.
module tb_shift_register;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         x_i;
    logic [W-1:0] sr_o;
    logic         clk_en;
    logic         chk_en;

    int pass_cnt;
    int total_cnt;

    shift_register #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .x_i   (x_i),
        .sr_o  (sr_o)
    );

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    // Model: bits sampled since the last reset, oldest first.
    logic hist[$];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist.delete();
        end else begin
            hist.push_back(x_i);
            if (hist.size() > W) void'(hist.pop_front());
        end
    end

    function automatic logic [W-1:0] model_val();
        logic [W-1:0] v;
        int n;
        v = '0;
        n = hist.size();
        for (int k = 0; k < W; k++) begin
            if (k < n) v[k] = hist[n-1-k];
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Continuous compare away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            if (!reset) check("reset_low", sr_o, '0);
            else        check("model", sr_o, model_val());
        end
    end

    task automatic step(input logic b);
        x_i = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] e;
        logic [W-1:0] pat_exp [5];
        logic         pat_in  [5];
        pass_cnt  = 0;
        total_cnt = 0;
        clk_en    = 1'b0;
        chk_en    = 1'b0;
        reset     = 1'b1;
        x_i       = 1'b0;

        // Async reset with the clock idle
        #5 reset = 1'b0;
        #1 check("async_rst_pulse", sr_o, 4'b0000);
        #1 reset = 1'b1;
        #1 check("async_rst_after", sr_o, 4'b0000);

        chk_en = 1'b1;
        clk_en = 1'b1;
        #1;

        // Serial pattern
        pat_in  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        pat_exp = '{4'b0000, 4'b0001, 4'b0010, 4'b0101, 4'b1011};
        for (int i = 0; i < 5; i++) begin
            step(pat_in[i]);
            check($sformatf("pattern_%0d", i), sr_o, pat_exp[i]);
        end

        // Saturation
        step(1'b1); check("sat_0", sr_o, 4'b0111);
        step(1'b1); check("sat_1", sr_o, 4'b1111);
        step(1'b1); check("sat_2", sr_o, 4'b1111);
        step(1'b1); check("sat_3", sr_o, 4'b1111);

        // Flush
        step(1'b0); check("flush_0", sr_o, 4'b1110);
        step(1'b0); check("flush_1", sr_o, 4'b1100);
        step(1'b0); check("flush_2", sr_o, 4'b1000);
        step(1'b0); check("flush_3", sr_o, 4'b0000);

        // Reset mid-operation at 0101
        step(1'b1); step(1'b0); step(1'b1);
        check("pre_mid_rst", sr_o, 4'b0101);
        #2 reset = 1'b0;
        #1 check("mid_rst", sr_o, 4'b0000);
        x_i = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1 check("post_rst_first", sr_o, 4'b0001);

        // No enable: every edge shifts
        e = 4'b0001;
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            e = {e[W-2:0], 1'b1};
            check($sformatf("const_%0d", i), sr_o, e);
        end

        // Random traffic with occasional mid-cycle resets
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 24) == 0) begin
                #2 reset = 1'b0;
                #1 check("rand_rst", sr_o, '0);
                reset = 1'b1;
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
